ntt_seq_ctrl: RTL

Sequential controller that computes a 16-point NTT with a single shared modular multiply-accumulate unit instead of a fully unrolled array. It accepts coefficients over a valid/ready stream, sequences row and column indices and the twiddle powers, and streams results out with backpressure. It sits between the coefficient source and downstream NTT consumers, and trades area for about N*N cycles of latency.

---
 rtl/ntt_seq_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ntt_seq_ctrl.sv
// Sequential 16-point NTT: a single modular multiply-accumulate unit is reused
// row by row, with a valid/ready coefficient input and a backpressured result stream.
module ntt_seq_ctrl #(
  parameter int N  = 16,
  parameter int DW = 4,
  parameter int QW = 8,
  parameter int WW = 5,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [QW-1:0] q_in,
  input  logic [WW-1:0] w_in,
  output logic          busy,
  output logic          err,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] out_data,
  output logic [IW-1:0] out_idx,
  output logic          done
);

  localparam int SW = DW + QW + 1;
  localparam int PW = 2 * QW;
  localparam int RW = WW + QW;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_OUT, S_ERR} state_t;

  state_t        state;
  logic [QW-1:0] q, wmod, r, tw, acc;
  logic [IW-1:0] i_cnt, j_cnt;
  logic [DW-1:0] cbuf [N];
  logic [QW-1:0] res  [N];
  logic [QW-1:0] mac;
  logic [QW-1:0] wmod_next;

  // Full-width sum of products before reduction; inputs at or above q reduce here.
  function automatic logic [QW-1:0] mac_mod(input logic [QW-1:0] acc_v,
                                            input logic [DW-1:0] a_v,
                                            input logic [QW-1:0] t_v,
                                            input logic [QW-1:0] m);
    logic [SW-1:0] s;
    s = SW'(acc_v) + SW'(a_v) * SW'(t_v);
    return QW'(s % SW'(m));
  endfunction

  function automatic logic [QW-1:0] mul_mod(input logic [QW-1:0] x,
                                            input logic [QW-1:0] y,
                                            input logic [QW-1:0] m);
    logic [PW-1:0] p;
    p = PW'(x) * PW'(y);
    return QW'(p % PW'(m));
  endfunction

  assign mac       = mac_mod(acc, cbuf[j_cnt], tw, q);
  assign wmod_next = QW'(RW'(w_in) % RW'(q_in));

  assign busy     = (state != S_IDLE);
  assign err      = (state == S_ERR);
  assign in_ready = (state == S_LOAD);
  // Pulse on the accepting beat itself, not the cycle after.
  assign done     = (state == S_OUT) && out_ready && (out_idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      q         <= '0;
      wmod      <= '0;
      r         <= '0;
      tw        <= '0;
      acc       <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      for (int n = 0; n < N; n++) begin
        cbuf[n] <= '0;
        res[n]  <= '0;
      end
    end else begin
      case (state)
        S_IDLE, S_ERR: begin
          if (start) begin
            if (q_in < QW'(2)) begin
              state <= S_ERR;
            end else begin
              q     <= q_in;
              wmod  <= wmod_next;
              r     <= QW'(1);
              j_cnt <= '0;
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            cbuf[j_cnt] <= in_data;
            j_cnt       <= j_cnt + IW'(1);
            if (j_cnt == LAST) begin
              state <= S_CALC;
              i_cnt <= '0;
              j_cnt <= '0;
              acc   <= '0;
              tw    <= QW'(1);
            end
          end
        end
        S_CALC: begin
          if (j_cnt == LAST) begin
            res[i_cnt] <= mac;
            r          <= mul_mod(r, wmod, q);
            tw         <= QW'(1);
            acc        <= '0;
            j_cnt      <= '0;
            i_cnt      <= i_cnt + IW'(1);
            if (i_cnt == LAST) begin
              state     <= S_OUT;
              out_valid <= 1'b1;
              out_data  <= res[0];
              out_idx   <= '0;
            end
          end else begin
            acc   <= mac;
            tw    <= mul_mod(tw, r, q);
            j_cnt <= j_cnt + IW'(1);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            if (out_idx == LAST) begin
              state     <= S_IDLE;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_idx   <= '0;
            end else begin
              out_idx  <= out_idx + IW'(1);
              out_data <= res[out_idx + IW'(1)];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
